// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EXE and WB.
//   Issues loads/stores to a variable-latency data memory over a
//   req/addr_ok/data_ok handshake and holds the instruction until the
//   response arrives. Formats load data, builds store strobes and lane
//   data, flags misaligned accesses and drives a forwarding bus to ID.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   exe_*                 instruction from EXE (valid/pc/op/result/store data/rd)
//   mem_allow_in          stage can take a new instruction this cycle
//   wb_allow_in           WB accepts the current result
//   mem_to_wb_valid, wb_* result, RF write controls and ALE flag to WB
//   fwd_*                 forwarding bus to ID; fwd_busy = load data not back yet
//   data_*                data-memory request/response channel
//
// exe_mem_op: [4] memory access, [3] store, [2] zero-extend,
//             [1:0] size (0 byte, 1 half, 2 word, 3 double)
module mem_access_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RF_AW  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exe_to_mem_valid,
  output logic                mem_allow_in,
  input  logic [PC_W-1:0]     exe_pc,
  input  logic [4:0]          exe_mem_op,
  input  logic [DATA_W-1:0]   exe_result,
  input  logic [DATA_W-1:0]   exe_st_data,
  input  logic                exe_rf_wen,
  input  logic [RF_AW-1:0]    exe_rd,
  input  logic                wb_allow_in,
  output logic                mem_to_wb_valid,
  output logic [PC_W-1:0]     wb_pc,
  output logic                wb_rf_wen,
  output logic [RF_AW-1:0]    wb_rf_waddr,
  output logic [DATA_W-1:0]   wb_rf_wdata,
  output logic                wb_ale,
  output logic                fwd_valid,
  output logic                fwd_busy,
  output logic [RF_AW-1:0]    fwd_waddr,
  output logic [DATA_W-1:0]   fwd_wdata,
  output logic                data_req,
  output logic                data_wr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_valid;
  logic [PC_W-1:0]     r_pc;
  logic [4:0]          r_op;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_st_data;
  logic                r_rf_wen;
  logic [RF_AW-1:0]    r_rd;
  logic [DATA_W-1:0]   r_ld_data;

  logic                w_is_mem;
  logic                w_is_st;
  logic                w_zext;
  logic [1:0]          w_size;
  logic                w_ale;
  logic                w_mem_go;
  logic                w_in_mem_go;
  logic                w_ready_go;
  logic                w_capture;
  logic [OFFW-1:0]     w_off;
  logic [DATA_W-1:0]   w_lane;
  logic [DATA_W-1:0]   w_mask;
  logic                w_sign;
  logic [DATA_W-1:0]   w_ld_fmt;
  logic [NB-1:0]       w_strb_base;
  logic [DATA_W-1:0]   w_wdata;
  state_t              w_leave_state;

  // Misalignment: size 3 cannot be carried by a 32-bit bus at all.
  function automatic logic f_ale(input logic [4:0] op, input logic [2:0] a);
    logic res;
    res = 1'b0;
    if (op[4]) begin
      case (op[1:0])
        2'd0:    res = 1'b0;
        2'd1:    res = a[0];
        2'd2:    res = |a[1:0];
        default: res = (DATA_W == 32) ? 1'b1 : |a[2:0];
      endcase
    end
    return res;
  endfunction

  assign w_is_mem    = r_op[4];
  assign w_is_st     = r_op[3];
  assign w_zext      = r_op[2];
  assign w_size      = r_op[1:0];
  assign w_ale       = f_ale(r_op, r_result[2:0]);
  assign w_mem_go    = w_is_mem && !w_ale;
  assign w_in_mem_go = exe_mem_op[4] && !f_ale(exe_mem_op, exe_result[2:0]);
  assign w_off       = r_result[OFFW-1:0];

  always_comb begin
    w_ready_go = 1'b1;
    if (w_mem_go) begin
      case (r_state)
        S_WAIT:  w_ready_go = data_data_ok;
        S_DONE:  w_ready_go = 1'b1;
        default: w_ready_go = 1'b0;
      endcase
    end
  end

  assign mem_allow_in  = !r_valid || (w_ready_go && wb_allow_in);
  assign w_capture     = mem_allow_in && exe_to_mem_valid;
  // Leaving WAIT/DONE may hand straight over to the next captured memory op.
  assign w_leave_state = (w_capture && w_in_mem_go) ? S_REQ : S_IDLE;

  // Load formatting: shift the addressed lane down, mask to size, extend.
  assign w_lane = data_rdata >> {w_off, 3'b000};

  always_comb begin
    w_mask = '0;
    w_sign = 1'b0;
    case (w_size)
      2'd0: begin
        w_mask[7:0] = '1;
        w_sign      = w_lane[7];
      end
      2'd1: begin
        w_mask[15:0] = '1;
        w_sign       = w_lane[15];
      end
      2'd2: begin
        w_mask[31:0] = '1;
        w_sign       = w_lane[31];
      end
      default: begin
        w_mask = '1;
        w_sign = 1'b0;
      end
    endcase
  end

  assign w_ld_fmt = (w_lane & w_mask) | ((w_sign && !w_zext) ? ~w_mask : '0);

  // Store lanes: strobe mask shifted to the byte offset, data replicated.
  always_comb begin
    w_strb_base = '0;
    w_wdata     = r_st_data;
    case (w_size)
      2'd0: begin
        w_strb_base[0] = 1'b1;
        w_wdata        = {NB{r_st_data[7:0]}};
      end
      2'd1: begin
        w_strb_base[1:0] = '1;
        w_wdata          = {(NB/2){r_st_data[15:0]}};
      end
      2'd2: begin
        w_strb_base[3:0] = '1;
        w_wdata          = {(NB/4){r_st_data[31:0]}};
      end
      default: begin
        w_strb_base = '1;
        w_wdata     = r_st_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_st_data <= '0;
      r_rf_wen  <= 1'b0;
      r_rd      <= '0;
    end else begin
      if (mem_allow_in) begin
        r_valid <= exe_to_mem_valid;
      end
      if (w_capture) begin
        r_pc      <= exe_pc;
        r_op      <= exe_mem_op;
        r_result  <= exe_result;
        r_st_data <= exe_st_data;
        r_rf_wen  <= exe_rf_wen;
        r_rd      <= exe_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ld_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture && w_in_mem_go) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (wb_allow_in) begin
              r_state <= w_leave_state;
            end else begin
              r_state   <= S_DONE;
              r_ld_data <= w_ld_fmt;
            end
          end
        end
        default: begin
          if (wb_allow_in) begin
            r_state <= w_leave_state;
          end
        end
      endcase
    end
  end

  assign data_req   = (r_state == S_REQ);
  assign data_wr    = w_is_mem && w_is_st;
  assign data_wstrb = (w_is_mem && w_is_st) ? (w_strb_base << w_off) : '0;
  assign data_addr  = {r_result[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign data_wdata = w_wdata;

  assign mem_to_wb_valid = r_valid && w_ready_go;
  assign wb_pc           = r_pc;
  assign wb_rf_wen       = r_valid && r_rf_wen && (r_rd != '0) && !w_ale;
  assign wb_rf_waddr     = r_rd;
  assign wb_ale          = r_valid && w_ale;

  always_comb begin
    wb_rf_wdata = r_result;
    if (w_mem_go && !w_is_st) begin
      wb_rf_wdata = (r_state == S_DONE) ? r_ld_data : w_ld_fmt;
    end
  end

  assign fwd_valid = wb_rf_wen;
  assign fwd_waddr = r_rd;
  assign fwd_wdata = wb_rf_wdata;
  assign fwd_busy  = wb_rf_wen && w_mem_go && !w_is_st &&
                     ((r_state == S_REQ) || ((r_state == S_WAIT) && !data_data_ok));

endmodule
